// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between two producers, pending-write scoreboard.
// Latency: accepted write appears on the Wr_* port exactly one cycle after the transfer; 1 write/cycle.
// Backpressure: the losing requester sees rdy=0 and must hold its request; both rdy held low in reset.
module regfile_wb_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v0,
  input  logic [4:0]   rd0,
  input  logic [n-1:0] d0,
  output logic         rdy0,
  input  logic         v1,
  input  logic [4:0]   rd1,
  input  logic [n-1:0] d1,
  output logic         rdy1,
  input  logic         alloc_en,
  input  logic [4:0]   alloc_rd,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic         busy1,
  output logic         busy2,
  output logic         Wr_en,
  output logic [4:0]   Wr_rd,
  output logic [n-1:0] Wr_data
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins the first contest.
  logic          last_grant;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic          xfer;
  logic          xfer_wr;
  logic [4:0]    sel_rd;
  logic [n-1:0]  sel_d;

  // Grant: a lone requester wins outright; a contest goes to the one not granted last time.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (rst) begin
      if (v0 && v1) begin
        rdy0 = last_grant;
        rdy1 = ~last_grant;
      end else begin
        rdy0 = v0;
        rdy1 = v1;
      end
    end
  end

  // Mux the winning request; rd=0 transfers are accepted but never written.
  always_comb begin
    xfer    = rdy0 | rdy1;
    sel_rd  = rdy1 ? rd1 : rd0;
    sel_d   = rdy1 ? d1 : d0;
    xfer_wr = xfer && (sel_rd != 5'd0);
  end

  // Last-grant pointer follows every transfer, contested or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= rdy1;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Wr_en   <= 1'b0;
      Wr_rd   <= 5'd0;
      Wr_data <= '0;
    end else begin
      Wr_en <= xfer_wr;
      if (xfer_wr) begin
        Wr_rd   <= sel_rd;
        Wr_data <= sel_d;
      end
    end
  end

  // Scoreboard next state: clear on write-back, then set on allocation so a newer producer wins.
  always_comb begin
    pending_nxt = pending;
    if (xfer_wr) begin
      pending_nxt[sel_rd] = 1'b0;
    end
    if (alloc_en && (alloc_rd != 5'd0)) begin
      pending_nxt[alloc_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Busy covers both outstanding producers and the write sitting on the port this cycle.
  always_comb begin
    busy1 = (rs1 != 5'd0) && (pending[rs1] || (Wr_en && (Wr_rd == rs1)));
    busy2 = (rs2 != 5'd0) && (pending[rs2] || (Wr_en && (Wr_rd == rs2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled shortly after, well before the rising edge.
// The model tracks grant history, pending registers and the one write in flight.
module tb_regfile_wb_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, rdy0, rdy1;
  logic [4:0]   rd0, rd1, alloc_rd, rs1, rs2, Wr_rd;
  logic [N-1:0] d0, d1, Wr_data;
  logic         alloc_en, busy1, busy2, Wr_en;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.n(N)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .rd0(rd0), .d0(d0), .rdy0(rdy0),
    .v1(v1), .rd1(rd1), .d1(d1), .rdy1(rdy1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
    .Wr_en(Wr_en), .Wr_rd(Wr_rd), .Wr_data(Wr_data)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           m_last;
  bit           m_pend[32];
  bit           m_wen;
  logic [4:0]   m_wrd;
  logic [N-1:0] m_wdat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int grant_of(input bit a, input bit b);
    if (a && b) return (m_last == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  function automatic bit busy_of(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    return m_pend[rs] || (m_wen && (m_wrd == rs));
  endfunction

  task automatic model_reset();
    m_last = 1;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_wen  = 1'b0;
    m_wrd  = 5'd0;
    m_wdat = '0;
  endtask

  task automatic drive(input bit a, input logic [4:0] ra, input logic [N-1:0] da,
                       input bit b, input logic [4:0] rb, input logic [N-1:0] db,
                       input bit ae, input logic [4:0] ar,
                       input logic [4:0] s1, input logic [4:0] s2);
    v0 = a; rd0 = ra; d0 = da;
    v1 = b; rd1 = rb; d1 = db;
    alloc_en = ae; alloc_rd = ar;
    rs1 = s1; rs2 = s2;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    drive(0, 5'd0, '0, 0, 5'd0, '0, 0, 5'd0, s1, s2);
  endtask

  // Check all outputs against the model for the current inputs, then advance one clock.
  task automatic step(input string tag);
    int g;
    logic [4:0]   r;
    logic [N-1:0] d;
    #1;
    g = grant_of(v0, v1);
    check_eq($sformatf("%s rdy0", tag), rdy0, g == 0);
    check_eq($sformatf("%s rdy1", tag), rdy1, g == 1);
    check_eq($sformatf("%s onehot", tag), rdy0 & rdy1, 1'b0);
    check_eq($sformatf("%s busy1", tag), busy1, busy_of(rs1));
    check_eq($sformatf("%s busy2", tag), busy2, busy_of(rs2));
    check_eq($sformatf("%s wen", tag), Wr_en, m_wen);
    if (m_wen) begin
      check_eq($sformatf("%s wrd", tag), Wr_rd, m_wrd);
      check_eq($sformatf("%s wdata", tag), Wr_data, m_wdat);
    end
    @(posedge clk);
    m_wen = 1'b0;
    if (g >= 0) begin
      r = (g == 1) ? rd1 : rd0;
      d = (g == 1) ? d1 : d0;
      m_last = g;
      if (r != 5'd0) begin
        m_wen  = 1'b1;
        m_wrd  = r;
        m_wdat = d;
        m_pend[r] = 1'b0;
      end
    end
    if (alloc_en && alloc_rd != 5'd0) m_pend[alloc_rd] = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(5'd0, 5'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_g[4];
    // Reset state, with a request present to confirm rdy is held low.
    rst = 1'b0;
    drive(1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 0, 5'd0, 5'd5, 5'd6);
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst rdy0", rdy0, 1'b0);
    check_eq("rst rdy1", rdy1, 1'b0);
    check_eq("rst wen", Wr_en, 1'b0);
    check_eq("rst wrd", Wr_rd, 5'd0);
    check_eq("rst wdata", Wr_data, 32'd0);
    check_eq("rst busy1", busy1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single write from requester 0
    drive(1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, '0, 0, 5'd0, 5'd0, 5'd0);
    #1 check_eq("s1 rdy0", rdy0, 1'b1);
    step("s1a");
    idle(5'd0, 5'd0);
    #1;
    check_eq("s1 wen", Wr_en, 1'b1);
    check_eq("s1 wrd", Wr_rd, 5'd5);
    check_eq("s1 wdata", Wr_data, 32'hA5A5A5A5);
    step("s1b");
    #1 check_eq("s1 wen drop", Wr_en, 1'b0);
    step("s1c");

    // Sustained contest alternates starting with requester 0
    do_reset();
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd3, 32'h30 + i, 1, 5'd4, 32'h40 + i, 0, 5'd0, 5'd0, 5'd0);
      #1 check_eq($sformatf("rr grant%0d", i), rdy1, exp_g[i] == 1);
      if (i > 0) check_eq($sformatf("rr wrd%0d", i), Wr_rd, (exp_g[i-1] == 0) ? 5'd3 : 5'd4);
      step($sformatf("rr%0d", i));
    end
    idle(5'd0, 5'd0);
    step("rr tail");

    // Scoreboard set, bypass through the write cycle, then clear
    drive(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd7, 5'd7, 5'd0);
    step("sb alloc");
    drive(0, 5'd0, '0, 1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd0);
    #1 check_eq("sb busy pend", busy1, 1'b1);
    step("sb xfer");
    idle(5'd7, 5'd0);
    #1 check_eq("sb busy wen", busy1, 1'b1);
    check_eq("sb busy2 r0", busy2, 1'b0);
    step("sb wen");
    #1 check_eq("sb busy clr", busy1, 1'b0);
    step("sb clr");

    // Allocation and write-back to the same register in one cycle
    drive(1, 5'd9, 32'h99, 0, 5'd0, '0, 1, 5'd9, 5'd9, 5'd0);
    step("same xfer");
    idle(5'd9, 5'd0);
    step("same wen");
    #1 check_eq("same busy", busy1, 1'b1);
    check_eq("same wen off", Wr_en, 1'b0);
    step("same after");

    // rd=0 write-back advances the pointer but writes nothing
    drive(0, 5'd0, '0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd0);
    #1 check_eq("r0 rdy1", rdy1, 1'b1);
    step("r0 xfer");
    drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 5'd0, 5'd0, 5'd0);
    #1 check_eq("r0 wen", Wr_en, 1'b0);
    check_eq("r0 next grant", rdy0, 1'b1);
    step("r0 contest");

    // Reset in the middle of a transfer
    drive(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd12, 5'd12, 5'd0);
    step("mr alloc");
    drive(1, 5'd12, 32'hC, 0, 5'd0, '0, 0, 5'd0, 5'd12, 5'd0);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mr wen", Wr_en, 1'b0);
    check_eq("mr busy", busy1, 1'b0);
    check_eq("mr rdy0", rdy0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5'd13, 32'hD, 1, 5'd14, 32'hE, 0, 5'd0, 5'd12, 5'd0);
    #1 check_eq("mr first grant", rdy0, 1'b1);
    step("mr contest");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: n, default 32, data width of write-back values and of the register-file write port.
REQ-002 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports: v0 / rd0 / d0  input  1 / 5 / n  requester 0 (pipeline write-back): valid, destination register, data.
REQ-005 SHALL have ports: rdy0  output  1  requester 0 accepted this cycle.
REQ-006 SHALL have ports: v1 / rd1 / d1  input  1 / 5 / n  requester 1 (multi-cycle unit write-back): valid, destination register, data.
REQ-007 SHALL have ports: rdy1  output  1  requester 1 accepted this cycle.
REQ-008 SHALL have ports: alloc_en / alloc_rd  input  1 / 5  issue-time reservation of a destination register.
REQ-009 SHALL have ports: rs1 / rs2  input  5 / 5  source registers to be checked for pending writes.
REQ-010 SHALL have ports: busy1 / busy2  output  1 / 1  rs1 / rs2 value is not yet valid in the register file.
REQ-011 SHALL have ports: Wr_en / Wr_rd / Wr_data  output  1 / 5 / n  single register-file write port (to Wr_en, rd, Wr_data).

Function
REQ-012 SHALL complete a transfer on requester k only when vk=1 and rdyk=1 in the same cycle; rdyk SHALL be combinational from v0, v1 and the priority pointer.
REQ-013 SHALL grant a lone valid requester immediately: v0=1,v1=0 -> rdy0=1; v1=1,v0=0 -> rdy1=1; neither valid -> both rdy=0.
REQ-014 SHALL resolve v0=v1=1 round-robin: grant the requester not granted most recently, as recorded in a 1-bit last-grant pointer.
REQ-015 SHALL update the last-grant pointer to the granted index on every transfer, whether or not the request was contested.
REQ-016 SHALL never assert rdy0 and rdy1 in the same cycle.
REQ-017 SHALL register the granted write: in the cycle after a transfer with rd!=0, Wr_en=1 and Wr_rd/Wr_data equal the accepted rd/d. Latency is exactly 1 cycle, with 1 write per cycle sustained.
REQ-018 SHALL accept a transfer with rd=0 (rdy asserted, pointer updated) and drive Wr_en=0 on the following cycle.
REQ-019 SHALL drive Wr_en=0 in any cycle not following a transfer; Wr_rd and Wr_data SHALL hold their last values.
REQ-020 SHALL keep a 32-bit pending scoreboard; alloc_en=1 with alloc_rd!=0 sets pending[alloc_rd] on the clock edge. Bit 0 is never set.
REQ-021 SHALL clear pending[rd] on the edge of a transfer for rd!=0.
REQ-022 SHALL give set priority when alloc and transfer target the same rd in one cycle: the bit stays 1, because a newer producer exists.
REQ-023 SHALL leave the bit set with no error when alloc_en targets an already-pending register.
REQ-024 SHALL compute busyX = pending[rsX] OR (Wr_en AND Wr_rd==rsX), forced to 0 when rsX=0. The term covers the cycle before the register file commits the write.
REQ-025 SHALL raise no flag for a transfer to a non-pending rd; the write proceeds normally.

Reset
REQ-026 SHALL, while rst=0 and independent of clk, clear all state: pending=0, last-grant pointer=1 (requester 0 wins the first contest), Wr_en=0, Wr_rd=0, Wr_data=0.
REQ-027 SHALL hold rdy0=rdy1=0 while rst=0; a transfer in flight when reset asserts is discarded (no Wr_en after release).
REQ-028 SHALL resume normal arbitration on the first rising clk edge after rst returns to 1.

Verification
REQ-029 SHALL cover: reset, then v0=1 rd0=5 d0=0xA5A5A5A5 for 1 cycle -> rdy0=1 that cycle; next cycle Wr_en=1, Wr_rd=5, Wr_data=0xA5A5A5A5; following cycle Wr_en=0.
REQ-030 SHALL cover: v0=v1=1 held 4 cycles with distinct rd0=3, rd1=4 -> grants 0,1,0,1; Wr_rd sequence 3,4,3,4 one cycle later; rdy0 and rdy1 never both 1.
REQ-031 SHALL cover: alloc_en rd=7 -> busy1=1 with rs1=7; v1=1 rd1=7 transfer -> busy1 stays 1 in the Wr_en cycle, 0 the cycle after; rs2=0 -> busy2=0 always.
REQ-032 SHALL cover: alloc_en rd=9 in the same cycle as a transfer to rd=9 -> pending[9] remains 1, busy1=1 for rs1=9 after Wr_en drops.
REQ-033 SHALL cover: transfer with rd1=0 d1=0xFFFFFFFF -> rdy1=1, next cycle Wr_en=0, pointer advanced (next contest grants requester 0).
REQ-034 SHALL cover: rst=0 asserted mid-cycle during a transfer with pending[12]=1 -> Wr_en=0, busy for rs1=12 = 0 immediately; after release first contest grants requester 0.
